// File: rtl/fetch_decode_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_if : bus bundle between the fetch/decode front end and its
// surroundings (program memory, execute-stage redirect, downstream decode
// consumer).
//
//   Program memory : o_mem_req, o_mem_addr -> / <- i_mem_ack, i_mem_data
//   Redirect       : i_branch, i_branch_target
//   Decode output  : o_valid, o_pc, o_opcode, o_dsel, o_asel, o_bsel,
//                    o_imm_sel, o_imm  -> / <- i_ready
//
// Modports:
//   master : the fetch_decode stage itself
//   slave  : the environment (memory, execute, downstream consumer)
// ---------------------------------------------------------------------------
interface fetch_decode_if;
   logic        o_mem_req;
   logic [15:0] o_mem_addr;
   logic        i_mem_ack;
   logic [15:0] i_mem_data;
   logic        i_branch;
   logic [15:0] i_branch_target;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_pc;
   logic [3:0]  o_opcode;
   logic [1:0]  o_dsel;
   logic [1:0]  o_asel;
   logic [1:0]  o_bsel;
   logic        o_imm_sel;
   logic [15:0] o_imm;

   modport master (
      output o_mem_req, o_mem_addr,
      input  i_mem_ack, i_mem_data,
      input  i_branch, i_branch_target,
      output o_valid, o_pc, o_opcode, o_dsel, o_asel, o_bsel, o_imm_sel, o_imm,
      input  i_ready
   );

   modport slave (
      input  o_mem_req, o_mem_addr,
      output i_mem_ack, i_mem_data,
      output i_branch, i_branch_target,
      input  o_valid, o_pc, o_opcode, o_dsel, o_asel, o_bsel, o_imm_sel, o_imm,
      output i_ready
   );
endinterface

// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode : front-end stage of the 16-bit CPU.
//
// Fetches instruction words over a req/ack handshake, keeps the PC, and
// presents each decoded instruction (opcode, register selects, immediate)
// with a valid/ready handshake. LDI instructions carry a second word that
// becomes the immediate. A branch pulse from execute redirects the PC and
// cancels whatever is in flight.
//
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : fetch_decode_if.master (memory, redirect and decode signals)
//
// Instruction layout (bit 0 = MSB, i.e. bit 0 is word[15]):
//   [0:3] opcode  [4:5] dsel  [6:7] asel  [8:9] bsel
//   [10]  imm5 present        [11:15] signed imm5
// ---------------------------------------------------------------------------
module fetch_decode #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  LDI_OP   = 4'b1111
) (
   input  logic           i_clk,
   input  logic           i_rst,
   fetch_decode_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      FETCH_EXT,
      ISSUE,
      REDIRECT
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] pc;
   logic        is_ldi;
   logic [3:0]  opcode;
   logic [1:0]  dsel;
   logic [1:0]  asel;
   logic [1:0]  bsel;
   logic        imm_sel;
   logic [15:0] imm;

   logic        mem_req;
   logic [15:0] mem_addr;
   logic        valid;
   logic        word_ack;
   logic        ext_ack;
   logic        handshake;

   function automatic logic [15:0] sext_imm5(input logic [4:0] f);
      return {{11{f[4]}}, f};
   endfunction

   // A branch in the same cycle as an ack discards the returned word.
   assign word_ack  = (state == FETCH)     && bus.i_mem_ack && !bus.i_branch;
   assign ext_ack   = (state == FETCH_EXT) && bus.i_mem_ack && !bus.i_branch;
   assign handshake = (state == ISSUE)     && bus.i_ready;

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_addr  = pc;
      valid     = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (bus.i_mem_ack)
               state_nxt = (bus.i_mem_data[15:12] == LDI_OP) ? FETCH_EXT : ISSUE;
         end
         FETCH_EXT: begin
            mem_req  = 1'b1;
            mem_addr = pc + 16'd1;
            if (bus.i_mem_ack)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            valid = 1'b1;
            if (bus.i_ready)
               state_nxt = FETCH;
         end
         REDIRECT: state_nxt = FETCH;
         default:  state_nxt = IDLE;
      endcase
      // Redirect wins over every other transition; REDIRECT itself then
      // spends one cycle with the request low to drop the stale fetch.
      if (bus.i_branch)
         state_nxt = REDIRECT;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         is_ldi  <= 1'b0;
         opcode  <= 4'd0;
         dsel    <= 2'd0;
         asel    <= 2'd0;
         bsel    <= 2'd0;
         imm_sel <= 1'b0;
         imm     <= 16'd0;
      end else begin
         state <= state_nxt;

         if (bus.i_branch)
            pc <= bus.i_branch_target;
         else if (handshake)
            pc <= pc + (is_ldi ? 16'd2 : 16'd1);

         if (word_ack) begin
            opcode <= bus.i_mem_data[15:12];
            dsel   <= bus.i_mem_data[11:10];
            asel   <= bus.i_mem_data[9:8];
            bsel   <= bus.i_mem_data[7:6];
            if (bus.i_mem_data[15:12] == LDI_OP) begin
               // Immediate arrives with the extension word.
               is_ldi  <= 1'b1;
               imm_sel <= 1'b1;
            end else begin
               is_ldi  <= 1'b0;
               imm_sel <= bus.i_mem_data[5];
               imm     <= bus.i_mem_data[5] ? sext_imm5(bus.i_mem_data[4:0]) : 16'd0;
            end
         end

         if (ext_ack)
            imm <= bus.i_mem_data;
      end
   end

   assign bus.o_mem_req  = mem_req;
   assign bus.o_mem_addr = mem_addr;
   assign bus.o_valid    = valid;
   assign bus.o_pc       = pc;
   assign bus.o_opcode   = opcode;
   assign bus.o_dsel     = dsel;
   assign bus.o_asel     = asel;
   assign bus.o_bsel     = bsel;
   assign bus.o_imm_sel  = imm_sel;
   assign bus.o_imm      = imm;

endmodule

// File: tb/tb_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode : directed bench for fetch_decode.
// An instruction-level model (PC, pending LDI word, issued flag) tracks what
// the front end must present; a negedge process compares against it every
// cycle, and the directed sequence pins literal values.
// ---------------------------------------------------------------------------
module tb_fetch_decode;

   localparam logic [15:0] RST_PC = 16'h0010;

   logic clk;
   logic rst;
   logic ack_en;
   logic force_ack;
   logic [15:0] mem [0:65535];

   int checks;
   int errors;

   fetch_decode_if bus ();

   fetch_decode #(.RESET_PC(RST_PC), .LDI_OP(4'hF)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory: zero-wait when ack_en=1; force_ack injects stray acks.
   assign bus.i_mem_ack  = (ack_en && bus.o_mem_req) || force_ack;
   assign bus.i_mem_data = mem[bus.o_mem_addr];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instruction-level reference model ----------------
   logic [15:0] m_pc;
   logic        m_have;    // a complete instruction is being presented
   logic        m_first;   // first word of an LDI already received
   logic        m_quiet;   // cycle after reset/branch: no request allowed
   logic        armed;

   function automatic logic is_ldi_word(input logic [15:0] w);
      return (w / 4096) == 15;
   endfunction

   always @(negedge clk) begin
      logic [15:0] w;
      logic [15:0] e_imm;
      logic        e_sel;
      int          f5;
      if (armed) begin
         chk("valid", {15'd0, bus.o_valid}, {15'd0, m_have});
         if (m_quiet)
            chk("req_quiet", {15'd0, bus.o_mem_req}, 16'd0);
         if (bus.o_mem_req)
            chk("req_addr", bus.o_mem_addr, m_first ? m_pc + 16'd1 : m_pc);
         if (bus.o_valid) begin
            w = mem[m_pc];
            chk("req_in_issue", {15'd0, bus.o_mem_req}, 16'd0);
            chk("pc", bus.o_pc, m_pc);
            chk("opcode", {12'd0, bus.o_opcode}, w / 4096);
            chk("dsel", {14'd0, bus.o_dsel}, (w / 1024) % 4);
            chk("asel", {14'd0, bus.o_asel}, (w / 256) % 4);
            chk("bsel", {14'd0, bus.o_bsel}, (w / 64) % 4);
            if (is_ldi_word(w)) begin
               e_sel = 1'b1;
               e_imm = mem[m_pc + 16'd1];
            end else if (((w / 32) % 2) == 1) begin
               e_sel = 1'b1;
               f5 = int'(w % 32);
               if (f5 >= 16) f5 = f5 - 32;
               e_imm = 16'(f5);
            end else begin
               e_sel = 1'b0;
               e_imm = 16'd0;
            end
            chk("imm_sel", {15'd0, bus.o_imm_sel}, {15'd0, e_sel});
            chk("imm", bus.o_imm, e_imm);
         end
      end
      // Advance the model with the inputs that the next edge will see.
      if (rst) begin
         m_pc = RST_PC; m_have = 0; m_first = 0; m_quiet = 1; armed = 1;
      end else if (bus.i_branch) begin
         m_pc = bus.i_branch_target; m_have = 0; m_first = 0; m_quiet = 1;
      end else begin
         m_quiet = 0;
         if (bus.o_valid && bus.i_ready) begin
            m_pc = m_pc + (is_ldi_word(mem[m_pc]) ? 16'd2 : 16'd1);
            m_have = 0; m_first = 0;
         end else if (bus.o_mem_req && bus.i_mem_ack) begin
            if (is_ldi_word(mem[m_pc]) && !m_first) m_first = 1;
            else m_have = 1;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      checks = 0; errors = 0; armed = 0;
      m_pc = RST_PC; m_have = 0; m_first = 0; m_quiet = 1;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0010] = 16'h1A6B;
      mem[16'h0011] = 16'h203F;
      mem[16'h0012] = 16'h5C80;
      mem[16'h0013] = 16'h0000;
      mem[16'h0020] = 16'hF400;
      mem[16'h0021] = 16'hBEEF;
      mem[16'h0022] = 16'h4321;
      mem[16'h0400] = 16'h1234;
      mem[16'hFFFF] = 16'hF000;
      mem[16'h0000] = 16'h1357;

      rst = 1; ack_en = 0; force_ack = 0;
      bus.i_ready = 0; bus.i_branch = 0; bus.i_branch_target = 16'h0000;

      repeat (3) tick();
      chk("rst_req", {15'd0, bus.o_mem_req}, 16'd0);
      chk("rst_valid", {15'd0, bus.o_valid}, 16'd0);
      chk("rst_pc", bus.o_pc, 16'h0010);
      chk("rst_opcode", {12'd0, bus.o_opcode}, 16'd0);
      chk("rst_sels", {10'd0, bus.o_dsel, bus.o_asel, bus.o_bsel}, 16'd0);
      chk("rst_imm", bus.o_imm, 16'd0);
      chk("rst_imm_sel", {15'd0, bus.o_imm_sel}, 16'd0);
      rst = 0; ack_en = 1; bus.i_ready = 1;

      tick();   // IDLE -> FETCH
      chk("first_req", {15'd0, bus.o_mem_req}, 16'd1);
      chk("first_addr", bus.o_mem_addr, 16'h0010);
      tick();   // ISSUE 1A6B, one cycle after the request
      chk("w1_valid", {15'd0, bus.o_valid}, 16'd1);
      chk("w1_opcode", {12'd0, bus.o_opcode}, 16'h0001);
      chk("w1_dsel", {14'd0, bus.o_dsel}, 16'd2);
      chk("w1_asel", {14'd0, bus.o_asel}, 16'd2);
      chk("w1_bsel", {14'd0, bus.o_bsel}, 16'd1);
      chk("w1_imm", bus.o_imm, 16'h000B);
      chk("w1_imm_sel", {15'd0, bus.o_imm_sel}, 16'd1);
      tick();
      chk("w2_addr", bus.o_mem_addr, 16'h0011);
      tick();
      chk("w2_imm_neg", bus.o_imm, 16'hFFFF);
      tick();
      chk("w3_addr", bus.o_mem_addr, 16'h0012);
      bus.i_ready = 0;

      // Back-pressure with stray acks while no request is outstanding.
      tick();
      force_ack = 1;
      begin
         logic [15:0] snap_imm;
         logic [3:0]  snap_op;
         snap_imm = bus.o_imm;
         snap_op  = bus.o_opcode;
         repeat (5) begin
            tick();
            chk("bp_valid", {15'd0, bus.o_valid}, 16'd1);
            chk("bp_req", {15'd0, bus.o_mem_req}, 16'd0);
            chk("bp_imm", bus.o_imm, snap_imm);
            chk("bp_opcode", {12'd0, bus.o_opcode}, {12'd0, snap_op});
            chk("bp_pc", bus.o_pc, 16'h0012);
         end
      end
      force_ack = 0; bus.i_ready = 1;
      tick();
      chk("bp_advance_once", bus.o_mem_addr, 16'h0013);

      // Branch coinciding with a handshake.
      tick();
      bus.i_branch = 1; bus.i_branch_target = 16'h0020;
      tick();
      bus.i_branch = 0;
      chk("br1_req", {15'd0, bus.o_mem_req}, 16'd0);
      chk("br1_valid", {15'd0, bus.o_valid}, 16'd0);
      chk("br1_pc", bus.o_pc, 16'h0020);
      tick();
      chk("ldi_addr0", bus.o_mem_addr, 16'h0020);
      tick();
      chk("ldi_addr1", bus.o_mem_addr, 16'h0021);
      tick();
      chk("ldi_opcode", {12'd0, bus.o_opcode}, 16'h000F);
      chk("ldi_imm", bus.o_imm, 16'hBEEF);
      chk("ldi_imm_sel", {15'd0, bus.o_imm_sel}, 16'd1);
      tick();
      chk("ldi_next", bus.o_mem_addr, 16'h0022);
      ack_en = 0;

      // Branch during a wait-stated fetch, ack arriving in the same cycle.
      tick();
      tick();
      chk("ws_req", {15'd0, bus.o_mem_req}, 16'd1);
      chk("ws_addr", bus.o_mem_addr, 16'h0022);
      ack_en = 1; bus.i_branch = 1; bus.i_branch_target = 16'h0400;
      tick();
      bus.i_branch = 0;
      chk("br2_req", {15'd0, bus.o_mem_req}, 16'd0);
      chk("br2_valid", {15'd0, bus.o_valid}, 16'd0);
      tick();
      chk("br2_addr", bus.o_mem_addr, 16'h0400);
      chk("br2_no_valid", {15'd0, bus.o_valid}, 16'd0);
      tick();
      bus.i_ready = 0; bus.i_branch = 1; bus.i_branch_target = 16'hFFFF;
      tick();
      bus.i_branch = 0; bus.i_ready = 1;

      // Wrap-around LDI at 0xFFFF.
      tick();
      chk("wrap_addr0", bus.o_mem_addr, 16'hFFFF);
      tick();
      chk("wrap_addr1", bus.o_mem_addr, 16'h0000);
      tick();
      chk("wrap_pc", bus.o_pc, 16'hFFFF);
      chk("wrap_imm", bus.o_imm, 16'h1357);
      tick();
      chk("wrap_next", bus.o_mem_addr, 16'h0001);

      // Reset while a fetch is outstanding.
      ack_en = 0; rst = 1;
      tick();
      rst = 0; ack_en = 1;
      chk("mid_rst_valid", {15'd0, bus.o_valid}, 16'd0);
      chk("mid_rst_req", {15'd0, bus.o_mem_req}, 16'd0);
      chk("mid_rst_pc", bus.o_pc, 16'h0010);
      tick();
      chk("mid_rst_addr", bus.o_mem_addr, 16'h0010);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
